// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: peripheral, core handshake and register-window signals of the interrupt front-end
interface irq_ctrl_if;
  logic [3:0]  irq_in;
  logic [3:0]  ex_int;
  logic        int_ack;
  logic        int_ret;
  logic        busy;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  modport master (output irq_in, int_ack, int_ret, sel, we, addr, wd, input ex_int, busy, rd);
  modport slave  (input irq_in, int_ack, int_ret, sel, we, addr, wd, output ex_int, busy, rd);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronizes, edge-detects, masks and prioritizes peripheral interrupts into one-hot core requests
module irq_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] RESET_MASK  = 4'hF
) (
  input logic        clk,
  input logic        rst_n,
  irq_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] prev, rise, pending, lost, mask, ex_q, ex_n, pend_clr, lost_clr, cand;
  logic [1:0] active_id, aid_n, cand_id;
  logic [7:0] svc_cnt;
  logic       ack_take, wr_mask, wr_pend, busy, unused_wd;
  assign rise      = sync_q[SYNC_STAGES-1] & ~prev;
  assign ack_take  = (state == REQ) && bus.int_ack;
  assign wr_mask   = bus.sel && bus.we && bus.addr == 2'd0;
  assign wr_pend   = bus.sel && bus.we && bus.addr == 2'd1;
  assign pend_clr  = (ack_take ? 4'b0001 << active_id : 4'b0000) | (wr_pend ? bus.wd[3:0] : 4'b0000);
  assign lost_clr  = wr_pend ? bus.wd[7:4] : 4'b0000;
  assign cand      = pending & mask;
  assign cand_id   = cand[0] ? 2'd0 : cand[1] ? 2'd1 : cand[2] ? 2'd2 : 2'd3;
  assign busy      = state != IDLE;
  assign unused_wd = ^bus.wd[31:8];
  assign bus.ex_int = ex_q;
  assign bus.busy   = busy;
  assign bus.rd = !bus.sel          ? 32'h0 :
                  bus.addr == 2'd0  ? {28'h0, mask} :
                  bus.addr == 2'd1  ? {24'h0, lost, pending} :
                  bus.addr == 2'd2  ? {16'h0, svc_cnt, 3'b000, busy, active_id, state} : 32'h0;
  // synchronizer chain plus one history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end
  // sticky pending/lost bits (a new edge beats a same-cycle clear), mask and service counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      lost    <= '0;
      mask    <= RESET_MASK;
      svc_cnt <= '0;
    end else begin
      pending <= (pending & ~pend_clr) | rise;
      lost    <= (lost & ~lost_clr) | (rise & pending & ~pend_clr);
      mask    <= wr_mask ? bus.wd[3:0] : mask;
      svc_cnt <= svc_cnt + {7'h0, ack_take};
    end
  end
  // request FSM state, registered one-hot request and active source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ex_q      <= '0;
      active_id <= '0;
    end else begin
      state     <= state_n;
      ex_q      <= ex_n;
      active_id <= aid_n;
    end
  end
  // present one request, hold it until ack or mask-off, block new requests until return from ISR
  always_comb begin
    state_n = state;
    ex_n    = ex_q;
    aid_n   = active_id;
    case (state)
      IDLE: if (|cand) begin
        state_n = REQ;
        ex_n    = 4'b0001 << cand_id;
        aid_n   = cand_id;
      end
      REQ: if (bus.int_ack) begin
        state_n = SERVICE;
        ex_n    = '0;
      end else if (!mask[active_id]) begin
        state_n = IDLE;
        ex_n    = '0;
      end
      SERVICE: begin
        ex_n    = '0;
        state_n = bus.int_ret ? IDLE : SERVICE;
      end
      default: begin
        state_n = IDLE;
        ex_n    = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven and directed checks of the interrupt front-end
module tb_irq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_svc;
  irq_ctrl_if bus ();
  irq_ctrl #(.SYNC_STAGES(2), .RESET_MASK(4'hF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  irq;
    logic        ack;
    logic        ret;
    logic [1:0]  addr;
    logic [3:0]  ex;
    logic        busy;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.sel = 1'b1;
    bus.we = 1'b0;
    bus.addr = a;
    #1;
    chk(name, bus.rd, exp);
    bus.sel = 1'b0;
  endtask
  task automatic step(input logic [3:0] irq, input logic ack, input logic ret);
    bus.irq_in = irq;
    bus.int_ack = ack;
    bus.int_ret = ret;
    bus.sel = 1'b0;
    bus.we = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.irq_in = 4'h0;
    bus.int_ack = 1'b0;
    bus.int_ret = 1'b0;
    bus.sel = 1'b1;
    bus.we = 1'b1;
    bus.addr = a;
    bus.wd = d;
    @(posedge clk);
    #1;
    bus.sel = 1'b0;
    bus.we = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{4'b0010, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 32'h000};
    tbl[1]  = '{4'b0010, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 32'h000};
    tbl[2]  = '{4'b0010, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 32'h002};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b0010, 1'b1, 32'h015};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1, 32'h116};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1, 32'h000};
    tbl[6]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 32'h104};
    tbl[7]  = '{4'b1001, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 32'h000};
    tbl[8]  = '{4'b1001, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 32'h000};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 32'h009};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b0001, 1'b1, 32'h111};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1, 32'h212};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 32'h200};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b1000, 1'b1, 32'h21D};
    tbl[14] = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1, 32'h31E};
    tbl[15] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 32'h30C};
    bus.irq_in = 4'h0;
    bus.int_ack = 1'b0;
    bus.int_ret = 1'b0;
    bus.sel = 1'b0;
    bus.we = 1'b0;
    bus.addr = 2'd0;
    bus.wd = 32'h0;
    #7;
    chk("rst0_ex", {28'h0, bus.ex_int}, 32'h0);
    chk("rst0_busy", {31'h0, bus.busy}, 32'h0);
    rd_chk("rst0_mask", 2'd0, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      bus.irq_in = tbl[i].irq;
      bus.int_ack = tbl[i].ack;
      bus.int_ret = tbl[i].ret;
      bus.sel = 1'b1;
      bus.we = 1'b0;
      bus.addr = tbl[i].addr;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ex", i), {28'h0, bus.ex_int}, {28'h0, tbl[i].ex});
      chk($sformatf("tbl%0d_busy", i), {31'h0, bus.busy}, {31'h0, tbl[i].busy});
      chk($sformatf("tbl%0d_rd", i), bus.rd, tbl[i].rd);
    end
    bus.sel = 1'b0;
    exp_svc = 8'd3;
    step(4'b0100, 1'b0, 1'b0);
    repeat (3) step(4'h0, 1'b0, 1'b0);
    chk("lost_req_ex", {28'h0, bus.ex_int}, 32'h4);
    step(4'b0100, 1'b0, 1'b0);
    repeat (2) step(4'h0, 1'b0, 1'b0);
    rd_chk("lost_pend", 2'd1, 32'h44);
    step(4'b0100, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    exp_svc++;
    chk("simul_ex", {28'h0, bus.ex_int}, 32'h0);
    rd_chk("simul_pend", 2'd1, 32'h44);
    wr(2'd1, 32'h40);
    rd_chk("w1c_pend", 2'd1, 32'h04);
    step(4'h0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0);
    chk("repend_ex", {28'h0, bus.ex_int}, 32'h4);
    step(4'h0, 1'b1, 1'b0);
    exp_svc++;
    step(4'h0, 1'b0, 1'b1);
    wr(2'd0, 32'hE);
    rd_chk("mask_rd", 2'd0, 32'hE);
    step(4'b0001, 1'b0, 1'b0);
    repeat (3) step(4'h0, 1'b0, 1'b0);
    chk("masked_ex", {28'h0, bus.ex_int}, 32'h0);
    chk("masked_busy", {31'h0, bus.busy}, 32'h0);
    rd_chk("masked_pend", 2'd1, 32'h01);
    wr(2'd0, 32'hF);
    chk("unmask_edge_ex", {28'h0, bus.ex_int}, 32'h0);
    step(4'h0, 1'b0, 1'b0);
    chk("unmask_ex", {28'h0, bus.ex_int}, 32'h1);
    wr(2'd0, 32'hE);
    chk("remask_edge_ex", {28'h0, bus.ex_int}, 32'h1);
    step(4'h0, 1'b0, 1'b0);
    chk("remask_ex", {28'h0, bus.ex_int}, 32'h0);
    rd_chk("remask_stat", 2'd2, {16'h0, exp_svc, 8'h00});
    rd_chk("remask_pend", 2'd1, 32'h01);
    wr(2'd0, 32'hF);
    step(4'h0, 1'b0, 1'b0);
    chk("remask_again_ex", {28'h0, bus.ex_int}, 32'h1);
    step(4'h0, 1'b1, 1'b0);
    exp_svc++;
    step(4'h0, 1'b0, 1'b1);
    step(4'h0, 1'b1, 1'b0);
    rd_chk("ack_idle_ignored", 2'd2, {16'h0, exp_svc, 8'h00});
    step(4'b0010, 1'b0, 1'b0);
    repeat (3) step(4'h0, 1'b0, 1'b0);
    chk("nest_req_ex", {28'h0, bus.ex_int}, 32'h2);
    step(4'h0, 1'b1, 1'b0);
    exp_svc++;
    step(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(4'h0, 1'b0, 1'b0);
      chk($sformatf("nest_hold%0d_ex", i), {28'h0, bus.ex_int}, 32'h0);
    end
    chk("nest_busy", {31'h0, bus.busy}, 32'h1);
    step(4'h0, 1'b0, 1'b1);
    chk("nest_ret_ex", {28'h0, bus.ex_int}, 32'h0);
    chk("nest_ret_busy", {31'h0, bus.busy}, 32'h0);
    step(4'h0, 1'b0, 1'b0);
    chk("nest_next_ex", {28'h0, bus.ex_int}, 32'h1);
    step(4'h0, 1'b1, 1'b0);
    exp_svc++;
    step(4'h0, 1'b0, 1'b1);
    while (exp_svc != 8'hFF) begin
      step(4'b1000, 1'b0, 1'b0);
      repeat (3) step(4'h0, 1'b0, 1'b0);
      chk("wrap_req_ex", {28'h0, bus.ex_int}, 32'h8);
      step(4'h0, 1'b1, 1'b0);
      exp_svc++;
      step(4'h0, 1'b0, 1'b1);
    end
    rd_chk("svc_ff", 2'd2, 32'hFF0C);
    step(4'b1000, 1'b0, 1'b0);
    repeat (3) step(4'h0, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b1);
    rd_chk("svc_wrap", 2'd2, 32'h000C);
    wr(2'd0, 32'h3);
    step(4'b0010, 1'b0, 1'b0);
    repeat (3) step(4'h0, 1'b0, 1'b0);
    chk("prerst_ex", {28'h0, bus.ex_int}, 32'h2);
    rd_chk("prerst_pend", 2'd1, 32'h02);
    rst_n = 1'b0;
    #1;
    chk("rst_ex", {28'h0, bus.ex_int}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    rd_chk("rst_mask", 2'd0, 32'hF);
    rd_chk("rst_pend", 2'd1, 32'h0);
    rd_chk("rst_stat", 2'd2, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
